// File: rtl/ppc_ds_pkg.sv
// Shared definitions for the DS-format load/store path:
// opcodes, xo encodings, sequencer states and the DS displacement helper.
package ppc_ds_pkg;

  localparam logic [5:0] OPC_LD = 6'd58;
  localparam logic [5:0] OPC_ST = 6'd62;

  // ld/std, ldu/stdu, lwa/stq
  localparam logic [1:0] XO_D   = 2'd0;
  localparam logic [1:0] XO_U   = 2'd1;
  localparam logic [1:0] XO_W   = 2'd2;
  localparam logic [1:0] XO_BAD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_MEM,
    S_MEM2,
    S_WB_RT,
    S_WB_RA
  } state_e;

  function automatic logic [63:0] sext_ds(input logic [13:0] imm);
    return {{48{imm[13]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ds_loadstore_sequencer.sv
// Multi-cycle sequencer for DS-format integer loads/stores:
// EA calc, one or two memory transactions, then GPR writebacks.
module ds_loadstore_sequencer
  import ppc_ds_pkg::*;
#(
  parameter int regWidth  = 5,
  parameter int immWidth  = 14,
  parameter int dataWidth = 64
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 isStore_i,
  input  logic [1:0]           xo_i,
  input  logic [regWidth-1:0]  reg1_i,
  input  logic [regWidth-1:0]  reg2_i,
  input  logic                 reg2ValOrZero_i,
  input  logic [immWidth-1:0]  imm_i,
  input  logic [dataWidth-1:0] raVal_i,
  input  logic [dataWidth-1:0] rsVal_i,
  input  logic [dataWidth-1:0] rsNextVal_i,
  output logic                 stall_o,
  output logic                 illegal_o,
  output logic                 memReq_o,
  output logic                 memWe_o,
  output logic                 memWord_o,
  output logic [dataWidth-1:0] memAddr_o,
  output logic [dataWidth-1:0] memWData_o,
  input  logic                 memAck_i,
  input  logic [dataWidth-1:0] memRData_i,
  output logic                 wbEn_o,
  output logic [regWidth-1:0]  wbReg_o,
  output logic [dataWidth-1:0] wbData_o
);

  localparam logic [dataWidth-1:0] QW_STEP = dataWidth'(8);

  state_e state_q, state_d;

  logic [5:0]           opc_q;
  logic [1:0]           xo_q;
  logic [regWidth-1:0]  rt_q, ra_q;
  logic                 raz_q;
  logic [immWidth-1:0]  imm_q;
  logic [dataWidth-1:0] raVal_q, rsVal_q, rsNext_q;
  logic [dataWidth-1:0] ea_q, ea_d;

  logic                 stall_q, stall_d;
  logic                 ill_q, ill_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic                 word_q, word_d;
  logic [dataWidth-1:0] addr_q, addr_d;
  logic [dataWidth-1:0] wdat_q, wdat_d;
  logic                 wbEn_q, wbEn_d;
  logic [regWidth-1:0]  wbReg_q, wbReg_d;
  logic [dataWidth-1:0] wbDat_q, wbDat_d;

  logic accept, legal, is_st;
  logic [dataWidth-1:0] base, lwa_dat;

  assign accept = (state_q == S_IDLE) && enable_i;
  assign is_st  = (opc_q == OPC_ST);
  assign base   = (raz_q && ra_q == '0) ? '0 : raVal_q;
  assign lwa_dat = {{(dataWidth-32){memRData_i[31]}}, memRData_i[31:0]};

  always_comb begin
    legal = (xo_i != XO_BAD);
    if (xo_i == XO_U && reg2_i == '0) legal = 1'b0;
    if (!isStore_i && xo_i == XO_U && reg2_i == reg1_i) legal = 1'b0;
    if (isStore_i && xo_i == XO_W && reg1_i[0]) legal = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    ill_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wbEn_d  = 1'b0;
    wbReg_d = wbReg_q;
    wbDat_d = wbDat_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          if (legal) state_d = S_ADDR;
          else       ill_d   = 1'b1;
        end
      end
      S_ADDR: begin
        ea_d    = base + sext_ds(imm_q);
        state_d = S_MEM;
      end
      S_MEM: begin
        // First MEM cycle launches the request from the registered EA
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = ea_q;
          we_d   = is_st;
          word_d = !is_st && (xo_q == XO_W);
          wdat_d = is_st ? rsVal_q : '0;
        end else if (memAck_i) begin
          req_d = 1'b0;
          if (!is_st) begin
            wbEn_d  = 1'b1;
            wbReg_d = rt_q;
            wbDat_d = (xo_q == XO_W) ? lwa_dat : memRData_i;
            state_d = S_WB_RT;
          end else if (xo_q == XO_W) begin
            req_d   = 1'b1;
            addr_d  = ea_q + QW_STEP;
            wdat_d  = rsNext_q;
            state_d = S_MEM2;
          end else if (xo_q == XO_U) begin
            wbEn_d  = 1'b1;
            wbReg_d = ra_q;
            wbDat_d = ea_q;
            state_d = S_WB_RA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_MEM2: begin
        if (memAck_i) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WB_RT: begin
        if (xo_q == XO_U) begin
          wbEn_d  = 1'b1;
          wbReg_d = ra_q;
          wbDat_d = ea_q;
          state_d = S_WB_RA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB_RA: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    stall_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      xo_q     <= '0;
      rt_q     <= '0;
      ra_q     <= '0;
      raz_q    <= 1'b0;
      imm_q    <= '0;
      raVal_q  <= '0;
      rsVal_q  <= '0;
      rsNext_q <= '0;
      ea_q     <= '0;
      stall_q  <= 1'b0;
      ill_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      word_q   <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      wbEn_q   <= 1'b0;
      wbReg_q  <= '0;
      wbDat_q  <= '0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      stall_q <= stall_d;
      ill_q   <= ill_d;
      req_q   <= req_d;
      we_q    <= we_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wbEn_q  <= wbEn_d;
      wbReg_q <= wbReg_d;
      wbDat_q <= wbDat_d;
      if (accept) begin
        opc_q    <= isStore_i ? OPC_ST : OPC_LD;
        xo_q     <= xo_i;
        rt_q     <= reg1_i;
        ra_q     <= reg2_i;
        raz_q    <= reg2ValOrZero_i;
        imm_q    <= imm_i;
        raVal_q  <= raVal_i;
        rsVal_q  <= rsVal_i;
        rsNext_q <= rsNextVal_i;
      end
    end
  end

  assign stall_o    = stall_q;
  assign illegal_o  = ill_q;
  assign memReq_o   = req_q;
  assign memWe_o    = we_q;
  assign memWord_o  = word_q;
  assign memAddr_o  = addr_q;
  assign memWData_o = wdat_q;
  assign wbEn_o     = wbEn_q;
  assign wbReg_o    = wbReg_q;
  assign wbData_o   = wbDat_q;

endmodule

// File: tb/tb_ds_loadstore_sequencer.sv
// Directed self-checking bench for ds_loadstore_sequencer.
// Outputs are sampled 1ns after each rising edge.
module tb_ds_loadstore_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, st, z;
  logic [1:0]  xo;
  logic [4:0]  r1, r2;
  logic [13:0] imm;
  logic [63:0] raV, rsV, rsN;
  logic        stall, ill, req, we, word;
  logic [63:0] addr, wdat;
  logic        ack;
  logic [63:0] rdat;
  logic        wbEn;
  logic [4:0]  wbReg;
  logic [63:0] wbDat;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ds_loadstore_sequencer dut (
    .clock_i(clk), .reset_i(rst_n), .enable_i(en),
    .isStore_i(st), .xo_i(xo), .reg1_i(r1), .reg2_i(r2),
    .reg2ValOrZero_i(z), .imm_i(imm), .raVal_i(raV),
    .rsVal_i(rsV), .rsNextVal_i(rsN), .stall_o(stall),
    .illegal_o(ill), .memReq_o(req), .memWe_o(we),
    .memWord_o(word), .memAddr_o(addr), .memWData_o(wdat),
    .memAck_i(ack), .memRData_i(rdat), .wbEn_o(wbEn),
    .wbReg_o(wbReg), .wbData_o(wbDat)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic [1:0] x,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic zz, input logic [13:0] im,
                       input logic [63:0] ra, input logic [63:0] rs,
                       input logic [63:0] rn);
    st = s; xo = x; r1 = a; r2 = b; z = zz; imm = im;
    raV = ra; rsV = rs; rsN = rn; en = 1'b1;
    step;
    en = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++;
    if ({stall, ill, req, we, word, wbEn} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b exp 000000", {stall, ill, req, we, word, wbEn});
    end
    n_chk++;
    if ({addr, wdat, wbDat, wbReg} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h/%h/%h exp 0", addr, wdat, wbDat, wbReg);
    end
  endtask

  task automatic test_ld;
    issue(1'b0, 2'd0, 5'd5, 5'd0, 1'b1, 14'h0004, 64'hDEAD_0000, '0, '0);
    n_chk++;
    if (stall !== 1'b1 || req !== 1'b0) begin
      n_fail++; $display("FAIL ld_t0 stall=%b req=%b exp 1/0", stall, req);
    end
    step;
    n_chk++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL ld_t1_req got %b exp 0", req); end
    step;
    n_chk++;
    if (req !== 1'b1 || addr !== 64'h10 || we !== 1'b0 || word !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_req req=%b addr=%h we=%b word=%b exp 1/10/0/0", req, addr, we, word);
    end
    ack = 1'b1; rdat = 64'h1122334455667788;
    step;
    ack = 1'b0;
    n_chk++;
    if (req !== 1'b0 || wbEn !== 1'b1 || wbReg !== 5'd5 || wbDat !== 64'h1122334455667788) begin
      n_fail++;
      $display("FAIL ld_wb req=%b en=%b reg=%0d dat=%h exp 0/1/5/1122334455667788", req, wbEn, wbReg, wbDat);
    end
    step;
    n_chk++;
    if (stall !== 1'b0 || wbEn !== 1'b0) begin
      n_fail++; $display("FAIL ld_done stall=%b wbEn=%b exp 0/0", stall, wbEn);
    end
  endtask

  task automatic test_lwa;
    issue(1'b0, 2'd2, 5'd7, 5'd2, 1'b0, 14'h3FFF, 64'h1000, '0, '0);
    step; step;
    n_chk++;
    if (req !== 1'b1 || addr !== 64'hFFC || word !== 1'b1) begin
      n_fail++; $display("FAIL lwa_req req=%b addr=%h word=%b exp 1/ffc/1", req, addr, word);
    end
    ack = 1'b1; rdat = 64'hAAAABBBB80000001;
    step;
    ack = 1'b0;
    n_chk++;
    if (wbEn !== 1'b1 || wbReg !== 5'd7 || wbDat !== 64'hFFFFFFFF80000001) begin
      n_fail++;
      $display("FAIL lwa_wb en=%b reg=%0d dat=%h exp 1/7/ffffffff80000001", wbEn, wbReg, wbDat);
    end
    step;
  endtask

  task automatic test_ldu;
    issue(1'b0, 2'd1, 5'd6, 5'd3, 1'b0, 14'h0002, 64'h2000, '0, '0);
    step; step;
    n_chk++;
    if (addr !== 64'h2008 || req !== 1'b1) begin
      n_fail++; $display("FAIL ldu_addr got %h req=%b exp 2008/1", addr, req);
    end
    ack = 1'b1; rdat = 64'h0123456789ABCDEF;
    step;
    ack = 1'b0;
    n_chk++;
    if (wbEn !== 1'b1 || wbReg !== 5'd6 || wbDat !== 64'h0123456789ABCDEF || req !== 1'b0) begin
      n_fail++;
      $display("FAIL ldu_wbrt en=%b reg=%0d dat=%h req=%b exp 1/6/0123456789abcdef/0", wbEn, wbReg, wbDat, req);
    end
    step;
    n_chk++;
    if (wbEn !== 1'b1 || wbReg !== 5'd3 || wbDat !== 64'h2008 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL ldu_wbra en=%b reg=%0d dat=%h stall=%b exp 1/3/2008/1", wbEn, wbReg, wbDat, stall);
    end
    step;
    n_chk++;
    if (wbEn !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL ldu_done wbEn=%b stall=%b exp 0/0", wbEn, stall);
    end
  endtask

  task automatic test_stq;
    issue(1'b1, 2'd2, 5'd4, 5'd1, 1'b0, 14'h0000, 64'h100,
          64'hAAAA0000AAAA0000, 64'hBBBB1111BBBB1111);
    step; step;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (req !== 1'b1 || we !== 1'b1 || addr !== 64'h100 || wdat !== 64'hAAAA0000AAAA0000) begin
        n_fail++;
        $display("FAIL stq_first[%0d] req=%b we=%b addr=%h dat=%h exp 1/1/100/aaaa0000aaaa0000", i, req, we, addr, wdat);
      end
      step;
    end
    ack = 1'b1;
    step;
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (req !== 1'b1 || addr !== 64'h108 || wdat !== 64'hBBBB1111BBBB1111 || wbEn !== 1'b0) begin
        n_fail++;
        $display("FAIL stq_second[%0d] req=%b addr=%h dat=%h wbEn=%b exp 1/108/bbbb1111bbbb1111/0", i, req, addr, wdat, wbEn);
      end
      step;
    end
    ack = 1'b1;
    step;
    ack = 1'b0;
    n_chk++;
    if (req !== 1'b0 || stall !== 1'b0 || wbEn !== 1'b0) begin
      n_fail++; $display("FAIL stq_done req=%b stall=%b wbEn=%b exp 0/0/0", req, stall, wbEn);
    end
  endtask

  task automatic test_illegal;
    logic       s [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0] x [3] = '{2'd1, 2'd1, 2'd3};
    logic [4:0] a [3] = '{5'd2, 5'd4, 5'd4};
    logic [4:0] b [3] = '{5'd0, 5'd4, 5'd5};
    for (int i = 0; i < 3; i++) begin
      issue(s[i], x[i], a[i], b[i], 1'b0, 14'h0010, 64'h40, '0, '0);
      n_chk++;
      if (ill !== 1'b1 || stall !== 1'b0 || req !== 1'b0) begin
        n_fail++; $display("FAIL illegal_pulse[%0d] ill=%b stall=%b req=%b exp 1/0/0", i, ill, stall, req);
      end
      step;
      n_chk++;
      if (ill !== 1'b0 || req !== 1'b0 || stall !== 1'b0) begin
        n_fail++; $display("FAIL illegal_after[%0d] ill=%b req=%b stall=%b exp 0/0/0", i, ill, req, stall);
      end
    end
  endtask

  task automatic test_busy_ignore;
    issue(1'b1, 2'd0, 5'd2, 5'd1, 1'b0, 14'h0001, 64'h40, 64'hC0FFEE, '0);
    st = 1'b0; xo = 2'd3; rsV = 64'h5555; raV = 64'h9000; en = 1'b1;
    step;
    n_chk++;
    if (ill !== 1'b0) begin n_fail++; $display("FAIL busy_ill got %b exp 0", ill); end
    step;
    en = 1'b0;
    n_chk++;
    if (req !== 1'b1 || we !== 1'b1 || addr !== 64'h44 || wdat !== 64'hC0FFEE) begin
      n_fail++;
      $display("FAIL busy_std req=%b we=%b addr=%h dat=%h exp 1/1/44/c0ffee", req, we, addr, wdat);
    end
    ack = 1'b1;
    step;
    ack = 1'b0;
    n_chk++;
    if (stall !== 1'b0 || req !== 1'b0 || wbEn !== 1'b0 || ill !== 1'b0) begin
      n_fail++;
      $display("FAIL std_done stall=%b req=%b wbEn=%b ill=%b exp 0/0/0/0", stall, req, wbEn, ill);
    end
    step;
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 2'd0, 5'd9, 5'd1, 1'b0, 14'h0000, 64'h300, '0, '0);
    step; step;
    n_chk++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL rmid_req got %b exp 1", req); end
    rst_n = 1'b0;
    step;
    n_chk++;
    if (req !== 1'b0 || stall !== 1'b0 || wbEn !== 1'b0) begin
      n_fail++; $display("FAIL rmid_reset req=%b stall=%b wbEn=%b exp 0/0/0", req, stall, wbEn);
    end
    rst_n = 1'b1;
    ack = 1'b1;
    step;
    ack = 1'b0;
    n_chk++;
    if (wbEn !== 1'b0 || req !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after wbEn=%b req=%b stall=%b exp 0/0/0", wbEn, req, stall);
    end
    test_ld;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; st = 1'b0; xo = '0; r1 = '0; r2 = '0;
    z = 1'b0; imm = '0; raV = '0; rsV = '0; rsN = '0;
    ack = 1'b0; rdat = '0;
    step; step;
    test_reset;
    rst_n = 1'b1;
    step;
    test_ld;
    test_lwa;
    test_ldu;
    test_stq;
    test_illegal;
    test_busy_ignore;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
